// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state codes and the
// bundled stall/flush control word.
package pipeline_hazard_ctrl_pkg;

  typedef logic [1:0] ctrHazState_t;

  localparam logic [1:0] HAZ_RUN      = 2'd0;
  localparam logic [1:0] HAZ_MEM_WAIT = 2'd1;
  localparam logic [1:0] HAZ_MEM_ERR  = 2'd2;

  typedef struct packed {
    logic pcStall;
    logic ifIdStall;
    logic idExeStall;
    logic exeMemStall;
    logic ifIdFlush;
    logic idExeFlush;
    logic exeMemFlush;
    logic memWbBubble;
    logic memTimeout;
  } hazCtrl_t;

  localparam hazCtrl_t HAZ_CTRL_IDLE = 9'b0_0000_0000;

  // Whole pipeline frozen while MEM/WB receives a bubble.
  function automatic hazCtrl_t memStallCtrl();
    hazCtrl_t c;
    c             = HAZ_CTRL_IDLE;
    c.pcStall     = 1'b1;
    c.ifIdStall   = 1'b1;
    c.idExeStall  = 1'b1;
    c.exeMemStall = 1'b1;
    c.memWbBubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_chk.sv
// Protocol checker for pipeline_hazard_ctrl inputs and state encoding.
module pipeline_hazard_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       branchTakenMem,
  input logic       memReq,
  input logic [1:0] ctrlState
);

  // A MEM-stage instruction cannot be both a taken branch and a memory access.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(branchTakenMem && memReq))
        else $error("hazard_chk: branch_taken_mem and mem_req together");
      assert (ctrlState != 2'd3)
        else $error("hazard_chk: unused state code reached");
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Combinational load-use hazard compare between the ID sources and the EXE
// destination; kept standalone so the forwarding unit can reuse it.
module hazard_load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic [REG_ADDR_W-1:0] exeRd,
  input  logic                  exeMemRead,
  input  logic                  exeRegWe,
  output logic                  loadUse
);

  logic rdLive;
  logic rs1Hit;
  logic rs2Hit;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign rdLive  = exeMemRead & exeRegWe & (exeRd != {REG_ADDR_W{1'b0}});
  assign rs1Hit  = idUsesRs1 & (idRs1 == exeRd);
  assign rs2Hit  = idUsesRs2 & (idRs2 == exeRd);
  assign loadUse = rdLive & (rs1Hit | rs2Hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers, with a memory
// wait-timeout FSM. Optional perf counters built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_mem_read,
  input  logic                  exe_reg_we,
  input  logic                  branch_taken_mem,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_exe_stall,
  output logic                  exe_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_exe_flush,
  output logic                  exe_mem_flush,
  output logic                  mem_wb_bubble,
  output logic                  mem_timeout,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events,
  output logic [CNT_W-1:0]      loaduse_events
);

  // A zero MEM_TIMEOUT disables the timeout; keep the counter at least one bit wide.
  localparam int              TCNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(MEM_TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);
  localparam logic [TCNT_W-1:0] TCNT_ZERO = TCNT_W'(0);

  ctrHazState_t      state;
  ctrHazState_t      nextState;
  ctrHazState_t      runNext;
  logic [TCNT_W-1:0] tCnt;
  logic [TCNT_W-1:0] nextTCnt;
  logic [TCNT_W-1:0] runTCnt;
  hazCtrl_t          ctrl;
  hazCtrl_t          runCtrl;
  hazCtrl_t          outCtrl;
  logic              loadUse;

  hazard_load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) uLoadUse (
    .idRs1      (id_rs1),
    .idRs2      (id_rs2),
    .idUsesRs1  (id_uses_rs1),
    .idUsesRs2  (id_uses_rs2),
    .exeRd      (exe_rd),
    .exeMemRead (exe_mem_read),
    .exeRegWe   (exe_reg_we),
    .loadUse    (loadUse)
  );

  // RUN-state decode: memory stall beats branch flush beats load-use bubble.
  always_comb begin
    runCtrl = HAZ_CTRL_IDLE;
    runNext = HAZ_RUN;
    runTCnt = TCNT_ZERO;
    if (mem_req && !mem_ready) begin
      runCtrl = memStallCtrl();
      runNext = HAZ_MEM_WAIT;
      runTCnt = TCNT_ONE;
    end else if (branch_taken_mem) begin
      runCtrl.ifIdFlush   = 1'b1;
      runCtrl.idExeFlush  = 1'b1;
      runCtrl.exeMemFlush = 1'b1;
    end else if (loadUse) begin
      runCtrl.pcStall    = 1'b1;
      runCtrl.ifIdStall  = 1'b1;
      runCtrl.idExeFlush = 1'b1;
    end else begin
      runCtrl = HAZ_CTRL_IDLE;
    end
  end

  // Next-state, timeout counter and output decode per FSM state.
  always_comb begin
    ctrl      = HAZ_CTRL_IDLE;
    nextState = state;
    nextTCnt  = tCnt;
    case (state)
      HAZ_RUN: begin
        ctrl      = runCtrl;
        nextState = runNext;
        nextTCnt  = runTCnt;
      end
      HAZ_MEM_WAIT: begin
        if (mem_ready) begin
          nextState = HAZ_RUN;
          nextTCnt  = TCNT_ZERO;
        end else if (TIMEOUT_EN && (tCnt == TCNT_MAX)) begin
          ctrl      = memStallCtrl();
          nextState = HAZ_MEM_ERR;
          nextTCnt  = TCNT_ZERO;
        end else begin
          ctrl      = memStallCtrl();
          nextTCnt  = tCnt + TCNT_ONE;
        end
      end
      HAZ_MEM_ERR: begin
        ctrl.memTimeout  = 1'b1;
        ctrl.memWbBubble = 1'b1;
        nextState        = HAZ_RUN;
        nextTCnt         = TCNT_ZERO;
      end
      default: begin
        ctrl      = runCtrl;
        nextState = HAZ_RUN;
        nextTCnt  = TCNT_ZERO;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HAZ_RUN;
      tCnt  <= TCNT_ZERO;
    end else begin
      state <= nextState;
      tCnt  <= nextTCnt;
    end
  end

  // Outputs are forced quiet while reset is held, even with live inputs.
  assign outCtrl = rst ? ctrl : HAZ_CTRL_IDLE;

  assign pc_stall      = outCtrl.pcStall;
  assign if_id_stall   = outCtrl.ifIdStall;
  assign id_exe_stall  = outCtrl.idExeStall;
  assign exe_mem_stall = outCtrl.exeMemStall;
  assign if_id_flush   = outCtrl.ifIdFlush;
  assign id_exe_flush  = outCtrl.idExeFlush;
  assign exe_mem_flush = outCtrl.exeMemFlush;
  assign mem_wb_bubble = outCtrl.memWbBubble;
  assign mem_timeout   = outCtrl.memTimeout;
  assign ctrl_state    = state;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;
  logic [CNT_W-1:0] luCnt;
  logic             flushEv;
  logic             luEv;

  // Only a branch raises the IF/ID flush; a lone ID/EXE flush is a load-use bubble.
  assign flushEv = outCtrl.ifIdFlush;
  assign luEv    = outCtrl.idExeFlush & ~outCtrl.ifIdFlush;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= {CNT_W{1'b0}};
      flushCnt <= {CNT_W{1'b0}};
      luCnt    <= {CNT_W{1'b0}};
    end else begin
      if (outCtrl.pcStall && (stallCnt != CNT_MAX)) stallCnt <= stallCnt + CNT_ONE;
      if (flushEv && (flushCnt != CNT_MAX))         flushCnt <= flushCnt + CNT_ONE;
      if (luEv && (luCnt != CNT_MAX))               luCnt    <= luCnt + CNT_ONE;
    end
  end

  assign stall_cycles   = stallCnt;
  assign flush_events   = flushCnt;
  assign loaduse_events = luCnt;
`else
  assign stall_cycles   = {CNT_W{1'b0}};
  assign flush_events   = {CNT_W{1'b0}};
  assign loaduse_events = {CNT_W{1'b0}};
`endif

endmodule
